bulls_cows_core: RTL

Parametrised N-digit, radix-R "A/B" guessing-game controller: the successor to the fixed 4-digit decimal game FSM. It sits between the debounced push-button/switch inputs, the random-number source, the 7-segment nibble decoders and the LED bar. New over the previous generation:
- configurable digit count, radix and try budget;
- press-edge detection on buttons;
- sequential A/B scoring engine;
- duplicate-digit guess rejection that costs no try;
- secret validation.

---
 rtl/bulls_cows_core.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bulls_cows_core.sv
// N-digit, radix-R A/B guessing-game controller: press detection, secret capture,
// sequential A/B/duplicate scoring engine and registered display/LED outputs.
module bulls_cows_core #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned RADIX       = 10,
  parameter int unsigned MAX_TRIES   = 10,
  parameter int unsigned TITLE_TICKS = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  btn_inc_n,
  input  logic                  btn_next_n,
  input  logic                  btn_sub_n,
  input  logic                  cheat,
  input  logic [4*DIGITS-1:0]   rnd_in,
  output logic [4*DIGITS-1:0]   disp_val,
  output logic [DIGITS-1:0]     disp_dp,
  output logic [MAX_TRIES-1:0]  hp_bar,
  output logic [3:0]            a_cnt,
  output logic [3:0]            b_cnt,
  output logic                  win,
  output logic                  lose,
  output logic                  dup_err
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TW = $clog2(TITLE_TICKS + 1);
  localparam int unsigned AW = 6;

  typedef enum logic [2:0] {
    S_TITLE, S_INPUT, S_SCORE, S_SHOW, S_WIN, S_LOSE
  } state_t;

  // Digit k of a packed value, k = 0 being the leftmost (MS) nibble.
  function automatic logic [3:0] nib(input logic [VW-1:0] v, input int unsigned k);
    nib = v[4*(DIGITS-1-k) +: 4];
  endfunction

  function automatic logic [VW-1:0] seq_pattern();
    logic [VW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < DIGITS; k++) v[4*(DIGITS-1-k) +: 4] = 4'(k);
    return v;
  endfunction

  function automatic logic [VW-1:0] title_pattern();
    logic [VW-1:0] v;
    logic [15:0]   pat;
    pat = 16'h1A2B;
    v   = '0;
    for (int unsigned k = 0; k < DIGITS; k++) v[4*(DIGITS-1-k) +: 4] = pat[4*(3-(k%4)) +: 4];
    return v;
  endfunction

  function automatic logic rnd_valid(input logic [VW-1:0] v);
    rnd_valid = 1'b1;
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (nib(v, p) >= 4'(RADIX)) rnd_valid = 1'b0;
      for (int unsigned q = p + 1; q < DIGITS; q++)
        if (nib(v, p) == nib(v, q)) rnd_valid = 1'b0;
    end
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    inc_digit = (d == 4'(RADIX - 1)) ? 4'd0 : d + 4'd1;
  endfunction

  localparam logic [VW-1:0] SEQ_INIT  = seq_pattern();
  localparam logic [VW-1:0] TITLE_PAT = title_pattern();
  localparam logic [VW-1:0] ERR_PAT   = {DIGITS{4'hE}};

  state_t                state_q, state_d;
  logic [VW-1:0]         secret_q, secret_d, cand_q, cand_d, guess_q, guess_d;
  logic [IW-1:0]         cursor_q, cursor_d, si_q, si_d, sj_q, sj_d;
  logic [MAX_TRIES-1:0]  hp_d, hp_shift_c;
  logic [3:0]            a_d, b_d;
  logic [TW-1:0]         title_cnt_q, title_cnt_d;
  logic                  scan_done_q, scan_done_d;
  logic [AW-1:0]         acc_a_q, acc_a_d, acc_b_q, acc_b_d, acc_d_q, acc_d_d;
  logic                  samp_inc_q, samp_next_q, samp_sub_q;
  logic                  press_inc_c, press_next_c, press_sub_c, any_press_c;
  logic                  dup_err_d;
  logic [3:0]            gi_c, gj_c, si_dig_c;
  logic [VW-1:0]         disp_c;
  logic [DIGITS-1:0]     dp_c;

  // Press = released at the previous tick sample, pressed at this one.
  assign press_inc_c  = tick & samp_inc_q  & ~btn_inc_n;
  assign press_next_c = tick & samp_next_q & ~btn_next_n;
  assign press_sub_c  = tick & samp_sub_q  & ~btn_sub_n;
  assign any_press_c  = press_inc_c | press_next_c | press_sub_c;

  assign gi_c       = nib(guess_q,  32'(si_q));
  assign gj_c       = nib(guess_q,  32'(sj_q));
  assign si_dig_c   = nib(secret_q, 32'(si_q));
  assign hp_shift_c = hp_bar >> 1;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    secret_d    = secret_q;
    cand_d      = cand_q;
    guess_d     = guess_q;
    cursor_d    = cursor_q;
    hp_d        = hp_bar;
    a_d         = a_cnt;
    b_d         = b_cnt;
    title_cnt_d = title_cnt_q;
    si_d        = si_q;
    sj_d        = sj_q;
    scan_done_d = scan_done_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    acc_d_d     = acc_d_q;
    dup_err_d   = 1'b0;

    case (state_q)
      S_TITLE: begin
        if (tick && rnd_valid(rnd_in)) cand_d = rnd_in;
        if (!cheat) begin
          if (tick) title_cnt_d = title_cnt_q + TW'(1);
          if (any_press_c || (tick && title_cnt_q == TW'(TITLE_TICKS - 1))) begin
            state_d  = S_INPUT;
            secret_d = cand_d;
            guess_d  = '0;
            cursor_d = '0;
            hp_d     = '1;
          end
        end
      end
      S_INPUT: begin
        if (!cheat) begin
          if (press_sub_c) begin
            state_d     = S_SCORE;
            si_d        = '0;
            sj_d        = '0;
            scan_done_d = 1'b0;
            acc_a_d     = '0;
            acc_b_d     = '0;
            acc_d_d     = '0;
          end else begin
            if (press_inc_c)
              guess_d[4*(DIGITS-1-32'(cursor_q)) +: 4] = inc_digit(nib(guess_q, 32'(cursor_q)));
            if (press_next_c)
              cursor_d = (cursor_q == IW'(DIGITS - 1)) ? '0 : cursor_q + IW'(1);
          end
        end
      end
      S_SCORE: begin
        if (!scan_done_q) begin
          if (si_dig_c == gj_c) begin
            if (si_q == sj_q) acc_a_d = acc_a_q + AW'(1);
            else              acc_b_d = acc_b_q + AW'(1);
          end
          if (si_q < sj_q && gi_c == gj_c) acc_d_d = acc_d_q + AW'(1);
          if (sj_q == IW'(DIGITS - 1)) begin
            sj_d = '0;
            if (si_q == IW'(DIGITS - 1)) scan_done_d = 1'b1;
            else                         si_d = si_q + IW'(1);
          end else begin
            sj_d = sj_q + IW'(1);
          end
        end else if (acc_d_q != '0) begin
          dup_err_d = 1'b1;
          state_d   = S_INPUT;
        end else begin
          a_d = 4'(acc_a_q);
          b_d = 4'(acc_b_q);
          if (acc_a_q == AW'(DIGITS)) begin
            state_d = S_WIN;
          end else begin
            hp_d    = hp_shift_c;
            state_d = (hp_shift_c == '0) ? S_LOSE : S_SHOW;
          end
        end
      end
      S_SHOW: if (!cheat && press_next_c) state_d = S_INPUT;
      S_WIN: begin
        if (!cheat) begin
          if (tick) hp_d = MAX_TRIES'(hp_bar << 1) | MAX_TRIES'(hp_bar >> (MAX_TRIES - 1));
          if (press_next_c) state_d = S_TITLE;
        end
      end
      S_LOSE: if (!cheat && press_next_c) state_d = S_TITLE;
      default: state_d = S_TITLE;
    endcase

    // Cheat overrides everywhere except an in-flight scan.
    if (cheat && state_q != S_SCORE) begin
      if (press_inc_c)  hp_d    = MAX_TRIES'(hp_bar << 1) | MAX_TRIES'(1);
      if (press_next_c) state_d = S_TITLE;
    end

    if (state_d != S_TITLE) title_cnt_d = '0;
  end

  // Display content derived from the current registered state.
  always_comb begin
    disp_c = guess_q;
    dp_c   = '1;
    if (cheat && !btn_sub_n) begin
      disp_c = secret_q;
    end else begin
      case (state_q)
        S_TITLE: disp_c = TITLE_PAT;
        S_SHOW: begin
          disp_c            = {DIGITS{4'hF}};
          disp_c[VW-1 -: 4]  = a_cnt;
          disp_c[VW-5 -: 4]  = 4'hA;
          disp_c[VW-9 -: 4]  = b_cnt;
          disp_c[VW-13 -: 4] = 4'hB;
        end
        S_LOSE:  disp_c = !btn_inc_n ? secret_q : ERR_PAT;
        default: disp_c = guess_q;
      endcase
    end
    if (state_q == S_INPUT) dp_c[DIGITS-1-32'(cursor_q)] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_TITLE;
      secret_q    <= SEQ_INIT;
      cand_q      <= SEQ_INIT;
      guess_q     <= '0;
      cursor_q    <= '0;
      hp_bar      <= '1;
      a_cnt       <= '0;
      b_cnt       <= '0;
      title_cnt_q <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      scan_done_q <= 1'b0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      acc_d_q     <= '0;
      samp_inc_q  <= 1'b1;
      samp_next_q <= 1'b1;
      samp_sub_q  <= 1'b1;
      win         <= 1'b0;
      lose        <= 1'b0;
      dup_err     <= 1'b0;
      disp_val    <= TITLE_PAT;
      disp_dp     <= '1;
    end else begin
      state_q     <= state_d;
      secret_q    <= secret_d;
      cand_q      <= cand_d;
      guess_q     <= guess_d;
      cursor_q    <= cursor_d;
      hp_bar      <= hp_d;
      a_cnt       <= a_d;
      b_cnt       <= b_d;
      title_cnt_q <= title_cnt_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      scan_done_q <= scan_done_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      acc_d_q     <= acc_d_d;
      if (tick) begin
        samp_inc_q  <= btn_inc_n;
        samp_next_q <= btn_next_n;
        samp_sub_q  <= btn_sub_n;
      end
      win         <= (state_d == S_WIN);
      lose        <= (state_d == S_LOSE);
      dup_err     <= dup_err_d;
      disp_val    <= disp_c;
      disp_dp     <= dp_c;
    end
  end

endmodule
